// File: rtl/multi_lane_bit_sweep.sv
// Multi-lane bit-sweep fill engine: walks one bit index per clock across the masked lanes.
// Optional abort support is compiled in with `define BIT_SWEEP_ABORT_EN.
module multi_lane_bit_sweep #(
  parameter int              NCH       = 4,
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [NCH-1:0]           lane_mask,
  input  logic [WIDTH-1:0]         pat,
`ifdef BIT_SWEEP_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic [NCH*WIDTH-1:0]     lanes,
  output logic [1:0]               state_dbg
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  IDX_LAST = IW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             busy_q, done_q;
  logic             abort_hit;
  logic             sweep_wr;

  // Handshake: start has no ready; it is accepted only in IDLE with a non-zero
  // lane_mask, and busy high means any start is dropped (no queuing).
`ifdef BIT_SWEEP_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && (state_q == SWEEP);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (start && (|lane_mask)) begin
          mode_d  = mode;
          mask_d  = lane_mask;
          pat_d   = pat;
          idx_d   = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (abort_hit) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sweep_wr = (state_q == SWEEP) && !abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      pat_q   <= pat_d;
      busy_q  <= (state_d == SWEEP) || (state_d == DONE);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef BIT_SWEEP_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= abort_hit;
  end
`endif

  // Each lane owns its write enable and only reads its own current bit.
  for (genvar n = 0; n < NCH; n++) begin : g_lane
    logic [WIDTH-1:0] lane_q, lane_d;
    logic             wen;
    logic             new_bit;

    assign wen = sweep_wr && mask_q[n];

    always_comb begin
      case (mode_q)
        2'd0:    new_bit = 1'b1;
        2'd1:    new_bit = 1'b0;
        2'd2:    new_bit = ~lane_q[idx_q];
        default: new_bit = pat_q[idx_q];
      endcase
      lane_d = lane_q;
      if (wen) lane_d[idx_q] = new_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_q <= RESET_VAL;
      else        lane_q <= lane_d;
    end

    assign lanes[n*WIDTH +: WIDTH] = lane_q;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign idx       = idx_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multi_lane_bit_sweep.sv
// Bench for multi_lane_bit_sweep: directed steps plus random sweeps against a whole-lane model.
module tb_multi_lane_bit_sweep;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: NCH=4, WIDTH=8 ----------------
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [3:0]  lane_mask = '0;
  logic [7:0]  pat = '0;
  logic        busy, done;
  logic [2:0]  idx;
  logic [31:0] lanes;
  logic [1:0]  state_dbg;

  // ---------------- DUT B: NCH=2, WIDTH=5 ----------------
  localparam logic [4:0] RV5 = 5'b10100;
  logic        start5 = 1'b0;
  logic [1:0]  mode5 = '0;
  logic [1:0]  mask5 = '0;
  logic [4:0]  pat5 = '0;
  logic        busy5, done5;
  logic [2:0]  idx5;
  logic [9:0]  lanes5;
  logic [1:0]  state5;

`ifdef BIT_SWEEP_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
  logic abort5 = 1'b0;
  logic aborted5;
`endif

  multi_lane_bit_sweep #(.NCH(4), .WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lane_mask(lane_mask), .pat(pat),
`ifdef BIT_SWEEP_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .idx(idx), .lanes(lanes), .state_dbg(state_dbg)
  );

  multi_lane_bit_sweep #(.NCH(2), .WIDTH(5), .RESET_VAL(RV5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode5), .lane_mask(mask5), .pat(pat5),
`ifdef BIT_SWEEP_ABORT_EN
    .abort(abort5), .aborted(aborted5),
`endif
    .busy(busy5), .done(done5), .idx(idx5), .lanes(lanes5), .state_dbg(state5)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m8[4];
  logic [4:0]  m5[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack8();
    logic [31:0] v;
    for (int n = 0; n < 4; n++) v[n*8 +: 8] = m8[n];
    return v;
  endfunction

  function automatic logic [9:0] pack5();
    logic [9:0] v;
    for (int n = 0; n < 2; n++) v[n*5 +: 5] = m5[n];
    return v;
  endfunction

  // Whole-lane effect of a completed sweep.
  function automatic logic [7:0] op8(input logic [1:0] m, input logic [7:0] v, input logic [7:0] p);
    case (m)
      2'd0:    return 8'hFF;
      2'd1:    return 8'h00;
      2'd2:    return ~v;
      default: return p;
    endcase
  endfunction

  function automatic logic [4:0] op5(input logic [1:0] m, input logic [4:0] v, input logic [4:0] p);
    case (m)
      2'd0:    return 5'h1F;
      2'd1:    return 5'h00;
      2'd2:    return ~v;
      default: return p;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on DUT A, checking partial lane contents after every bit.
  task automatic run8(input logic [1:0] m, input logic [3:0] mk, input logic [7:0] p, input bit noise);
    logic [31:0] old_v, new_v, rep, e;
    int n;
    old_v = pack8();
    for (int l = 0; l < 4; l++) if (mk[l]) m8[l] = op8(m, m8[l], p);
    new_v = pack8();
    exp_q.push_back(new_v);
    start = 1'b1; mode = m; lane_mask = mk; pat = p;
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("idx_first", idx, 0);
    n = 0;
    while (!done && n < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mode = 2'($urandom_range(0, 3));
        lane_mask = 4'($urandom_range(0, 15));
        pat = 8'($urandom_range(0, 255));
      end
      tick();
      n++;
      if (!done) begin
        chk("idx_step", idx, n);
        chk("busy_hold", busy, 1);
        rep = {4{8'((1 << n) - 1)}};
        chk("lanes_partial", lanes, (old_v & ~rep) | (new_v & rep));
      end
    end
    start = 1'b0;
    chk("latency", n, 8);
    chk("done_idx", idx, 0);
    chk("busy_in_done", busy, 1);
    e = exp_q.pop_front();
    chk("lanes_final", lanes, e);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_fall", busy, 0);
  endtask

  task automatic run5(input logic [1:0] m, input logic [1:0] mk, input logic [4:0] p);
    logic [9:0] e;
    int n;
    for (int l = 0; l < 2; l++) if (mk[l]) m5[l] = op5(m, m5[l], p);
    e = pack5();
    start5 = 1'b1; mode5 = m; mask5 = mk; pat5 = p;
    tick();
    start5 = 1'b0;
    n = 0;
    while (!done5 && n < 40) begin
      tick();
      n++;
      if (!done5) chk("w5_idx_step", idx5, n);
    end
    chk("w5_latency", n, 5);
    chk("w5_idx_wrap", idx5, 0);
    chk("w5_lanes", lanes5, e);
    tick();
    chk("w5_busy_fall", busy5, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int l = 0; l < 4; l++) m8[l] = 8'h00;
    for (int l = 0; l < 2; l++) m5[l] = RV5;

    #12;
    chk("rst_lanes", lanes, 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", idx, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_lanes5", lanes5, {2{RV5}});
    rst_n = 1'b1;
    tick();

    run8(2'd0, 4'b0101, 8'h00, 0);
    chk("set_0101", lanes, 32'h00FF00FF);
    run8(2'd1, 4'b0001, 8'h00, 0);
    chk("clear_lane0", lanes, 32'h00FF0000);
    run8(2'd3, 4'b1111, 8'hA5, 0);
    chk("copy_a5", lanes, 32'hA5A5A5A5);
    run8(2'd2, 4'b0010, 8'h00, 0);
    chk("toggle_lane1", lanes, 32'hA5A55AA5);
    run8(2'd0, 4'b1000, 8'h00, 1);
    chk("busy_start_ignored", lanes, 32'hFFA55AA5);

    start = 1'b1; mode = 2'd1; lane_mask = 4'b0000; pat = 8'h00;
    tick();
    start = 1'b0;
    chk("mask0_busy", busy, 0);
    tick();
    chk("mask0_done", done, 0);
    chk("mask0_lanes", lanes, pack8());

    // Reset in the middle of a set sweep.
    start = 1'b1; mode = 2'd0; lane_mask = 4'b1111;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_idx", idx, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_lanes", lanes, 32'h0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_idx", idx, 0);
    for (int l = 0; l < 4; l++) m8[l] = 8'h00;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_no_done", done, 0);
    end

    run5(2'd0, 2'b01, 5'h00);
    run5(2'd2, 2'b11, 5'h00);
    run5(2'd3, 2'b10, 5'b01101);

`ifdef BIT_SWEEP_ABORT_EN
    abort = 1'b1;
    tick();
    chk("abort_idle_ignored", aborted, 0);
    abort = 1'b0;
    start = 1'b1; mode = 2'd0; lane_mask = 4'b0001;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_at_idx", idx, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m8[0] = m8[0] | 8'h07;
    chk("aborted_pulse", aborted, 1);
    chk("abort_no_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", idx, 0);
    chk("abort_lane0", lanes[7:0], 8'h07);
    tick();
    chk("aborted_one_cycle", aborted, 0);
    chk("abort_still_no_done", done, 0);
    run8(2'd0, 4'b0001, 8'h00, 0);
`endif

    for (int i = 0; i < 12; i++) begin
      logic [1:0] rm;
      logic [3:0] rk;
      logic [7:0] rp;
      rm = 2'($urandom_range(0, 3));
      rk = 4'($urandom_range(0, 15));
      rp = 8'($urandom_range(0, 255));
      if (rk == 4'b0) begin
        start = 1'b1; mode = rm; lane_mask = rk; pat = rp;
        tick();
        start = 1'b0;
        chk("rand_mask0_busy", busy, 0);
      end else begin
        run8(rm, rk, rp, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_lane_bit_sweep.md
Name: multi_lane_bit_sweep

Overview:
- Parametrised, multi-channel sequential successor to the combinational per-bit fill loops.
- Holds NCH lane registers of WIDTH bits each.
- On a start command, walks a bit index across the selected lanes one bit per clock and writes each bit according to a mode (set, clear, toggle, pattern copy).
- Sits as a small register-fill engine beside control logic that needs staged, observable bit initialisation of several lanes.

Parameters:
- NCH, 4, number of lanes (1..16).
- WIDTH, 8, bits per lane (2..64).
- RESET_VAL, 0, per-lane reset value (WIDTH bits, replicated to all lanes).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  2  0=set, 1=clear, 2=toggle, 3=copy pat; latched on accepted start.
- lane_mask  input  NCH  lanes written by this sweep; latched on accepted start.
- pat  input  WIDTH  pattern source for mode 3; latched on accepted start.
- busy  output  1  high in SWEEP and DONE.
- done  output  1  one-cycle pulse in DONE.
- idx  output  $clog2(WIDTH)  current bit index.
- lanes  output  NCH*WIDTH  lane registers; lane n occupies bits [n*WIDTH +: WIDTH].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; idx=0; busy=0; done=0.
  - Every lane = RESET_VAL.
  - Latched mode/mask/pat = 0.
  - Reset mid-sweep discards the sweep; lanes return to RESET_VAL.
- States are IDLE, SWEEP, DONE.
- IDLE:
  - start=1 with lane_mask!=0: latch mode, lane_mask, pat; idx=0; next state SWEEP.
  - start=1 with lane_mask==0: ignored; stay IDLE, no done.
- SWEEP, each cycle, for every lane n with latched mask[n]=1, write bit idx of lane n:
  - mode 0 -> 1.
  - mode 1 -> 0.
  - mode 2 -> inverted current value.
  - mode 3 -> pat[idx].
- SWEEP, unmasked lanes and all other bits: unchanged.
- SWEEP index control:
  - idx<WIDTH-1: idx increments.
  - idx==WIDTH-1: bit written, idx returns to 0, next state DONE.
- Sweep latency: exactly WIDTH cycles of SWEEP.
  - The write of bit k is visible on lanes the cycle after idx==k.
- DONE: done=1 for exactly one cycle, then IDLE.
  - Accepted start to done pulse = WIDTH+1 clocks.
- busy: registered; rises the cycle after the accepted start and falls the cycle after done.
- start while busy=1: ignored, no queuing. Inputs mode/mask/pat changing mid-sweep have no effect.
- Back-to-back: start asserted in the IDLE cycle immediately after DONE is accepted; there is no dead cycle beyond DONE.
- Lane write logic: one generate block per lane (genvar loop), each with its own per-lane write-enable. No lane depends on another lane's contents.
- idx width: $clog2(WIDTH). The terminal-compare at WIDTH-1 handles non-power-of-two WIDTH; idx never exceeds WIDTH-1.

Optional Feature:
- Macro BIT_SWEEP_ABORT_EN.
- With the macro defined:
  - Extra ports: abort input 1; aborted output 1.
  - abort=1 in SWEEP: the bit at the current idx is NOT written; idx=0; state returns to IDLE.
  - aborted pulses high for one cycle; done is not asserted.
  - Already-written bits are kept.
  - abort in IDLE or DONE is ignored; DONE still pulses.
  - aborted resets to 0.
- Without the macro: no abort/aborted ports; every accepted sweep runs to completion.

Test Plan:
- Reset with RESET_VAL=0, NCH=4, WIDTH=8; start, mode=0, lane_mask=4'b0101 -> done at clock 9 after start; lanes 0 and 2 = 8'hFF, lanes 1 and 3 = 8'h00; busy high 9 cycles.
- From that state, start mode=1, mask=4'b0001 -> lane0 = 8'h00, lane2 stays 8'hFF. Sample after 3 sweep cycles: lane0 = 8'hF8.
- Mode 3, pat=8'hA5, mask=4'b1111 -> all lanes 8'hA5. Then mode 2, mask=4'b0010 -> lane1 = 8'h5A, others 8'hA5.
- start during busy with a different mode/mask -> ignored. start with mask=0 in IDLE -> no busy, no done. start on the cycle after done -> accepted.
- Assert rst_n low at idx=4 of a mode-0 sweep -> immediate lanes=RESET_VAL, busy=0, done never pulses. Repeat with WIDTH=5 -> done after 6 clocks, idx wraps 4->0.
- BIT_SWEEP_ABORT_EN: mode 0, mask=1, abort at idx=3 -> lane0 = 8'h07, aborted pulse, no done. Next start completes normally.
